// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and types for the pipeline hazard controller.
//   FWD_RF / FWD_WB / FWD_MEM : ALU operand forward-select encodings
//   md_state_e                : multi-cycle mult/div sequencer states
//   MDU_LAT_DEFAULT           : default MDU latency (cycles from start to HI/LO valid)
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int unsigned MDU_LAT_DEFAULT = 32;

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle of pipeline-stage signals seen by the hazard controller
// and the stall/flush/forward controls it returns.
//   master : pipeline datapath side (drives stage specifiers/controls, receives controls)
//   slave  : hazard controller side
//   Parameter REG_W : register-specifier width.
interface hazard_ctrl_if #(
    parameter int unsigned REG_W = 5
);
    logic [REG_W-1:0] RsD, RtD, RsE, RtE;
    logic             BranchD, PCSrcD, JumpD, MdUseD, MdStartE;
    logic             MemtoRegE, RegWriteE;
    logic [REG_W-1:0] WriteRegE;
    logic             MemtoRegM, RegWriteM;
    logic [REG_W-1:0] WriteRegM;
    logic             RegWriteW;
    logic [REG_W-1:0] WriteRegW;
    logic             ImemRdyF;

    logic             StallF, StallD, FlushD, FlushE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             ForwardAD, ForwardBD;
    logic             MdBusy, MdDone;
    logic [31:0]      StallCnt, FlushCnt;

    modport master (
        output RsD, RtD, RsE, RtE, BranchD, PCSrcD, JumpD, MdUseD, MdStartE,
               MemtoRegE, RegWriteE, WriteRegE, MemtoRegM, RegWriteM, WriteRegM,
               RegWriteW, WriteRegW, ImemRdyF,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, ForwardAD,
               ForwardBD, MdBusy, MdDone, StallCnt, FlushCnt
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, BranchD, PCSrcD, JumpD, MdUseD, MdStartE,
               MemtoRegE, RegWriteE, WriteRegE, MemtoRegM, RegWriteM, WriteRegM,
               RegWriteW, WriteRegW, ImemRdyF,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, ForwardAD,
               ForwardBD, MdBusy, MdDone, StallCnt, FlushCnt
    );

endinterface

// File: rtl/hazard_ctrl_mdu_seq.sv
// mdu_seq: busy sequencer for the multi-cycle mult/div unit.
//   clk      : rising-edge clock
//   Reset    : synchronous active-high reset (aborts an operation, no MdDone)
//   MdStartE : mult/div valid in execute; ignored while busy
//   MdBusy   : operation in flight (MDU_LAT cycles after the start cycle)
//   MdDone   : one-cycle pulse in the last busy cycle, when HI/LO become valid
module mdu_seq
    import hazard_pkg::*;
#(
    parameter int unsigned MDU_LAT = MDU_LAT_DEFAULT,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk,
    input  logic Reset,
    input  logic MdStartE,
    output logic MdBusy,
    output logic MdDone
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MD_IDLE: begin
                if (MdStartE) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_W'(MDU_LAT - 1);
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    // Outputs read low while Reset is held so an aborted operation never pulses MdDone.
    always_comb begin
        MdBusy = !Reset && (state_q == MD_BUSY);
        MdDone = MdBusy && (cnt_q == '0);
    end

    // A new start while busy is blocked upstream by the HI/LO stall.
    a_no_start_while_busy: assert property (
        @(posedge clk) disable iff (Reset) !((state_q == MD_BUSY) && MdStartE)
    );

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing controller for the 5-stage MIPS pipeline.
//   clk   : rising-edge clock
//   Reset : synchronous active-high reset; stall/flush/forward outputs read 0 while high
//   hz    : hazard_ctrl_if.slave - stage specifiers/controls in; StallF/StallD/FlushD/
//           FlushE, ForwardAE/BE/AD/BD, MdBusy/MdDone and perf counters out.
// Optional build macro HAZARD_PERF_EN enables the saturating StallCnt/FlushCnt counters;
// without it both read 0 and no counter flops exist.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MDU_LAT = MDU_LAT_DEFAULT,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned CNT_W   = 8
) (
    input  logic          clk,
    input  logic          Reset,
    hazard_ctrl_if.slave  hz
);

    localparam logic [REG_W-1:0] RegZero = '0;

    logic       md_busy, md_done;
    logic       lwstall, brstall, mdstall, memstall, stall;
    logic       flush_d;
    logic [1:0] fwd_ae, fwd_be;
    logic       fwd_ad, fwd_bd;

    mdu_seq #(
        .MDU_LAT (MDU_LAT),
        .CNT_W   (CNT_W)
    ) u_mdu_seq (
        .clk      (clk),
        .Reset    (Reset),
        .MdStartE (hz.MdStartE),
        .MdBusy   (md_busy),
        .MdDone   (md_done)
    );

    always_comb begin
        lwstall  = hz.MemtoRegE && ((hz.RtE == hz.RsD) || (hz.RtE == hz.RtD));
        brstall  = hz.BranchD &&
                   ((hz.RegWriteE && ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD))) ||
                    (hz.MemtoRegM && ((hz.WriteRegM == hz.RsD) || (hz.WriteRegM == hz.RtD))));
        // MdStartE covers the start cycle itself, before md_busy rises.
        mdstall  = hz.MdUseD && (md_busy || hz.MdStartE);
        memstall = !hz.ImemRdyF;
        stall    = !Reset && (lwstall || brstall || mdstall || memstall);
        // Stall wins: the decode register cannot hold and clear at once.
        flush_d  = !Reset && (hz.PCSrcD || hz.JumpD) && !stall;
    end

    // Memory stage takes priority over writeback since it holds the younger result.
    always_comb begin
        fwd_ae = FWD_RF;
        fwd_be = FWD_RF;
        fwd_ad = 1'b0;
        fwd_bd = 1'b0;
        if (!Reset) begin
            if (hz.RsE != RegZero && hz.RegWriteM && hz.WriteRegM == hz.RsE) begin
                fwd_ae = FWD_MEM;
            end else if (hz.RsE != RegZero && hz.RegWriteW && hz.WriteRegW == hz.RsE) begin
                fwd_ae = FWD_WB;
            end
            if (hz.RtE != RegZero && hz.RegWriteM && hz.WriteRegM == hz.RtE) begin
                fwd_be = FWD_MEM;
            end else if (hz.RtE != RegZero && hz.RegWriteW && hz.WriteRegW == hz.RtE) begin
                fwd_be = FWD_WB;
            end
            fwd_ad = (hz.RsD != RegZero) && hz.RegWriteM && (hz.WriteRegM == hz.RsD);
            fwd_bd = (hz.RtD != RegZero) && hz.RegWriteM && (hz.WriteRegM == hz.RtD);
        end
    end

    assign hz.StallF    = stall;
    assign hz.StallD    = stall;
    assign hz.FlushE    = stall;
    assign hz.FlushD    = flush_d;
    assign hz.ForwardAE = fwd_ae;
    assign hz.ForwardBE = fwd_be;
    assign hz.ForwardAD = fwd_ad;
    assign hz.ForwardBD = fwd_bd;
    assign hz.MdBusy    = md_busy;
    assign hz.MdDone    = md_done;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (Reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if ((stall || flush_d) && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign hz.StallCnt = stall_cnt_q;
    assign hz.FlushCnt = flush_cnt_q;
`else
    assign hz.StallCnt = 32'd0;
    assign hz.FlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus randomized bench for hazard_ctrl against a behavioural model.
// Honours HAZARD_PERF_EN for the perf-counter expectations.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int unsigned LAT = 4;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_W(5)) hz ();

    hazard_ctrl #(
        .MDU_LAT (LAT),
        .REG_W   (5),
        .CNT_W   (8)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .hz    (hz)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: busy cycles still to come for the MDU, and perf counts.
    int          md_left = 0;
    logic [31:0] m_stall_cnt = 0;
    logic [31:0] m_flush_cnt = 0;
    logic        exp_stall, exp_flushd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [1:0] fwd_e(input logic [4:0] src);
        if (src == 0) return 2'b00;
        if (hz.RegWriteM && hz.WriteRegM == src) return 2'b10;
        if (hz.RegWriteW && hz.WriteRegW == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic fwd_d(input logic [4:0] src);
        return (src != 0) && hz.RegWriteM && (hz.WriteRegM == src);
    endfunction

    task automatic check_all();
        logic lw, br, md, on;
        on = !Reset;
        lw = hz.MemtoRegE && (hz.RtE == hz.RsD || hz.RtE == hz.RtD);
        br = hz.BranchD && ((hz.RegWriteE && (hz.WriteRegE == hz.RsD || hz.WriteRegE == hz.RtD))
             || (hz.MemtoRegM && (hz.WriteRegM == hz.RsD || hz.WriteRegM == hz.RtD)));
        md = hz.MdUseD && (md_left > 0 || hz.MdStartE);
        exp_stall  = on && (lw || br || md || !hz.ImemRdyF);
        exp_flushd = on && (hz.PCSrcD || hz.JumpD) && !exp_stall;
        check("StallF", 32'(hz.StallF), 32'(exp_stall));
        check("StallD", 32'(hz.StallD), 32'(exp_stall));
        check("FlushE", 32'(hz.FlushE), 32'(exp_stall));
        check("FlushD", 32'(hz.FlushD), 32'(exp_flushd));
        check("ForwardAE", 32'(hz.ForwardAE), on ? 32'(fwd_e(hz.RsE)) : 32'd0);
        check("ForwardBE", 32'(hz.ForwardBE), on ? 32'(fwd_e(hz.RtE)) : 32'd0);
        check("ForwardAD", 32'(hz.ForwardAD), 32'(on && fwd_d(hz.RsD)));
        check("ForwardBD", 32'(hz.ForwardBD), 32'(on && fwd_d(hz.RtD)));
        check("MdBusy", 32'(hz.MdBusy), 32'(on && md_left > 0));
        check("MdDone", 32'(hz.MdDone), 32'(on && md_left == 1));
`ifdef HAZARD_PERF_EN
        check("StallCnt", hz.StallCnt, m_stall_cnt);
        check("FlushCnt", hz.FlushCnt, m_flush_cnt);
`else
        check("StallCnt", hz.StallCnt, 32'd0);
        check("FlushCnt", hz.FlushCnt, 32'd0);
`endif
    endtask

    // One clock: inputs already set after a falling edge; check, clock, advance model.
    task automatic cycle(input bit do_check);
        #1;
        if (do_check) check_all();
        else begin
            exp_stall  = 1'b0;
            exp_flushd = 1'b0;
        end
        @(posedge clk);
        if (Reset) begin
            md_left     = 0;
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            if (md_left > 0) md_left--;
            else if (hz.MdStartE) md_left = LAT;
            if (exp_stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
            if ((exp_stall || exp_flushd) && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        Reset = 0;
        hz.RsD = 0; hz.RtD = 0; hz.RsE = 0; hz.RtE = 0;
        hz.BranchD = 0; hz.PCSrcD = 0; hz.JumpD = 0; hz.MdUseD = 0; hz.MdStartE = 0;
        hz.MemtoRegE = 0; hz.RegWriteE = 0; hz.WriteRegE = 0;
        hz.MemtoRegM = 0; hz.RegWriteM = 0; hz.WriteRegM = 0;
        hz.RegWriteW = 0; hz.WriteRegW = 0; hz.ImemRdyF = 1;
    endtask

    initial begin
        quiet();
        Reset = 1;
        @(negedge clk);
        cycle(1'b0);
        cycle(1'b1);                 // reset state: everything forced low
        quiet();
        cycle(1'b1);

        // Forwarding: memory beats writeback; $0 never forwards.
        quiet();
        hz.RegWriteM = 1; hz.WriteRegM = 8; hz.RegWriteW = 1; hz.WriteRegW = 8; hz.RsE = 8;
        #1 check("fwd_ae_mem", 32'(hz.ForwardAE), 32'd2);
        cycle(1'b1);
        hz.RsE = 0;
        #1 check("fwd_ae_zero", 32'(hz.ForwardAE), 32'd0);
        cycle(1'b1);

        // Load-use stall blocks a taken-branch flush, then releases.
        quiet();
        hz.MemtoRegE = 1; hz.RtE = 9; hz.RsD = 9; hz.PCSrcD = 1;
        #1 check("lw_stall", 32'(hz.StallD), 32'd1);
        check("lw_noflushd", 32'(hz.FlushD), 32'd0);
        cycle(1'b1);
        hz.MemtoRegE = 0;
        #1 check("lw_release", 32'(hz.StallD), 32'd0);
        cycle(1'b1);

        // Branch on an E-stage result, then forward it from M.
        quiet();
        hz.BranchD = 1; hz.RegWriteE = 1; hz.WriteRegE = 4; hz.RsD = 4;
        #1 check("br_stall", 32'(hz.StallD), 32'd1);
        cycle(1'b1);
        hz.RegWriteE = 0; hz.WriteRegE = 0; hz.RegWriteM = 1; hz.WriteRegM = 4; hz.PCSrcD = 1;
        #1 check("br_fwd_ad", 32'(hz.ForwardAD), 32'd1);
        check("br_flushd", 32'(hz.FlushD), 32'd1);
        cycle(1'b1);

        // MDU: start at cycle 0 with a HI/LO consumer waiting in decode.
        quiet();
        hz.MdUseD = 1;
        for (int c = 0; c <= 5; c++) begin
            hz.MdStartE = (c == 0);
            #1 check("md_busy_seq", 32'(hz.MdBusy), 32'(c >= 1 && c <= 4));
            check("md_done_seq", 32'(hz.MdDone), 32'(c == 4));
            check("md_stall_seq", 32'(hz.StallD), 32'(c <= 4));
            cycle(1'b1);
        end

        // Reset in cycle 2 of an operation aborts it with no MdDone.
        quiet();
        for (int c = 0; c <= 8; c++) begin
            hz.MdStartE = (c == 0);
            Reset = (c == 2);
            #1 if (c == 2) check("rst_stall_low", 32'(hz.StallD), 32'd0);
            if (c >= 2) check("rst_no_done", 32'(hz.MdDone), 32'd0);
            if (c == 3) check("rst_busy_low", 32'(hz.MdBusy), 32'd0);
            cycle(1'b1);
        end

        // Instruction memory not ready for three cycles.
        quiet();
        Reset = 1;
        cycle(1'b1);
        quiet();
        for (int c = 0; c < 4; c++) begin
            hz.ImemRdyF = (c == 3);
            #1 check("imem_stall", 32'(hz.StallF), 32'(c < 3));
            cycle(1'b1);
        end
`ifdef HAZARD_PERF_EN
        #1 check("imem_stallcnt", hz.StallCnt, 32'd3);
`endif

        // Randomized traffic over a small register space to provoke matches.
        for (int n = 0; n < 400; n++) begin
            Reset        = ($urandom_range(0, 63) == 0);
            hz.RsD       = 5'($urandom_range(0, 3));
            hz.RtD       = 5'($urandom_range(0, 3));
            hz.RsE       = 5'($urandom_range(0, 3));
            hz.RtE       = 5'($urandom_range(0, 3));
            hz.BranchD   = 1'($urandom_range(0, 1));
            hz.PCSrcD    = 1'($urandom_range(0, 1));
            hz.JumpD     = ($urandom_range(0, 5) == 0);
            hz.MdUseD    = ($urandom_range(0, 3) == 0);
            hz.MdStartE  = (md_left == 0) && ($urandom_range(0, 7) == 0);
            hz.MemtoRegE = ($urandom_range(0, 3) == 0);
            hz.RegWriteE = 1'($urandom_range(0, 1));
            hz.WriteRegE = 5'($urandom_range(0, 3));
            hz.MemtoRegM = ($urandom_range(0, 3) == 0);
            hz.RegWriteM = 1'($urandom_range(0, 1));
            hz.WriteRegM = 5'($urandom_range(0, 3));
            hz.RegWriteW = 1'($urandom_range(0, 1));
            hz.WriteRegW = 5'($urandom_range(0, 3));
            hz.ImemRdyF  = ($urandom_range(0, 7) != 0);
            cycle(1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
